// File: rtl/cpu_trace_capture.sv
// cpu_trace_capture: per-cycle commit trace FIFO with cycle/instruction counters,
// halt detection, watchdog timeout and drop accounting.
module cpu_trace_capture #(
  parameter int DATA_W     = 16,
  parameter int REG_AW     = 4,
  parameter int ADDR_W     = 16,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 32,
  parameter int WDOG_LIMIT = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] pc,
  input  logic              reg_write,
  input  logic [REG_AW-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              hlt,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [3:0]        ev_flags,
  output logic [ADDR_W-1:0] ev_pc,
  output logic [REG_AW-1:0] ev_reg,
  output logic [DATA_W-1:0] ev_rdata,
  output logic [ADDR_W-1:0] ev_maddr,
  output logic [DATA_W-1:0] ev_mdata,
  output logic [CNT_W-1:0]  ev_cycle,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  inst_count,
  output logic              halted,
  output logic              timeout,
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_count
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, HALTED, TIMEOUT} state_t;
  typedef struct packed {
    logic [3:0]        flags;
    logic [ADDR_W-1:0] pc;
    logic [REG_AW-1:0] rg;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] maddr;
    logic [DATA_W-1:0] mdata;
    logic [CNT_W-1:0]  cyc;
  } entry_t;
  state_t state_q, state_d;
  entry_t mem_q [DEPTH];
  entry_t ent;
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0] cnt_q;
  logic [CNT_W-1:0] cycle_q, inst_q, drop_q;
  logic ovf_q, cap, push, pop, full, acc, drop;
  always_comb begin
    cap = state_q == RUN && en;
    ent = '{flags: {hlt, mem_write, mem_read & ~mem_write, reg_write}, pc: pc, rg: write_reg,
            rdata: write_data, maddr: mem_addr, mdata: mem_write ? mem_wdata : mem_rdata, cyc: cycle_q};
    push = cap && |ent.flags;
    pop = cnt_q != '0 && ev_ready;
    full = cnt_q == (PW+1)'(DEPTH);
    acc = push && (!full || pop);
    drop = push && full && !pop;
    state_d = state_q;
    if (state_q == IDLE && en) state_d = RUN;
    // Halt outranks the watchdog when both land on the same cycle.
    if (state_q == RUN)
      state_d = !en ? IDLE : hlt ? HALTED : (cycle_q + 1'b1 == CNT_W'(WDOG_LIMIT)) ? TIMEOUT : RUN;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      cycle_q <= '0;
      inst_q  <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        mem_q[wr_q] <= ent;
        wr_q <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{PW{1'b0}}, acc} - {{PW{1'b0}}, pop};
      if (cap) cycle_q <= cycle_q + 1'b1;
      if (cap && (hlt | reg_write | mem_write)) inst_q <= inst_q + 1'b1;
      if (drop) ovf_q <= 1'b1;
      if (drop && ~&drop_q) drop_q <= drop_q + 1'b1;
    end
  end
  assign ev_valid    = cnt_q != '0;
  assign ev_flags    = mem_q[rd_q].flags;
  assign ev_pc       = mem_q[rd_q].pc;
  assign ev_reg      = mem_q[rd_q].rg;
  assign ev_rdata    = mem_q[rd_q].rdata;
  assign ev_maddr    = mem_q[rd_q].maddr;
  assign ev_mdata    = mem_q[rd_q].mdata;
  assign ev_cycle    = mem_q[rd_q].cyc;
  assign cycle_count = cycle_q;
  assign inst_count  = inst_q;
  assign halted      = state_q == HALTED;
  assign timeout     = state_q == TIMEOUT;
  assign overflow    = ovf_q;
  assign drop_count  = drop_q;
endmodule

// File: tb/tb_cpu_trace_capture.sv
// tb_cpu_trace_capture: directed checks of trace capture, FIFO, counters, halt and watchdog.
module tb_cpu_trace_capture;
  logic clk = 1'b0, rst_n, en, reg_write, mem_read, mem_write, hlt, ev_ready;
  logic [15:0] pc, write_data, mem_addr, mem_wdata, mem_rdata;
  logic [3:0] write_reg;
  logic ev_valid, halted, timeout, overflow;
  logic [3:0] ev_flags, ev_reg;
  logic [15:0] ev_pc, ev_rdata, ev_maddr, ev_mdata;
  logic [31:0] ev_cycle, cycle_count, inst_count, drop_count;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  cpu_trace_capture #(.DEPTH(4), .WDOG_LIMIT(20)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pc(pc), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .hlt(hlt), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_flags(ev_flags), .ev_pc(ev_pc), .ev_reg(ev_reg),
    .ev_rdata(ev_rdata), .ev_maddr(ev_maddr), .ev_mdata(ev_mdata), .ev_cycle(ev_cycle),
    .cycle_count(cycle_count), .inst_count(inst_count), .halted(halted), .timeout(timeout),
    .overflow(overflow), .drop_count(drop_count));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    {en, reg_write, mem_read, mem_write, hlt} = '0;
    {pc, write_data, mem_addr, mem_wdata, mem_rdata, write_reg} = '0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    clr();
    step();
    rst_n = 1'b1;
  endtask
  initial begin
    ev_ready = 1'b0;
    do_reset();
    chk("rst_valid", ev_valid, 0);
    chk("rst_flags", ev_flags, 0);
    chk("rst_cycle", cycle_count, 0);
    chk("rst_inst", inst_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_state", {halted, timeout}, 0);
    en = 1; ev_ready = 1;
    step();
    reg_write = 1; write_reg = 3; write_data = 16'h1234; pc = 16'h0010;
    step();
    chk("reg_valid", ev_valid, 1);
    chk("reg_flags", ev_flags, 4'b0001);
    chk("reg_idx", ev_reg, 3);
    chk("reg_data", ev_rdata, 16'h1234);
    chk("reg_pc", ev_pc, 16'h0010);
    chk("reg_cyc", ev_cycle, 0);
    chk("reg_inst", inst_count, 1);
    mem_write = 1; mem_addr = 16'h0040; mem_wdata = 16'hBEEF; pc = 16'h0014;
    step();
    chk("st_flags", ev_flags, 4'b0101);
    chk("st_mdata", ev_mdata, 16'hBEEF);
    chk("st_maddr", ev_maddr, 16'h0040);
    chk("st_cyc", ev_cycle, 1);
    chk("st_inst", inst_count, 2);
    reg_write = 0; mem_write = 0; mem_read = 1; mem_rdata = 16'h00AA;
    step();
    chk("ld_flags", ev_flags, 4'b0010);
    chk("ld_mdata", ev_mdata, 16'h00AA);
    chk("ld_inst", inst_count, 2);
    chk("ld_cycle", cycle_count, 3);
    mem_read = 0;
    step();
    chk("drain_valid", ev_valid, 0);
    ev_ready = 0; reg_write = 1;
    for (int i = 0; i < 6; i++) begin
      write_data = 16'h0100 + 16'(i);
      step();
    end
    chk("ovf_head", ev_rdata, 16'h0100);
    chk("ovf_cyc", ev_cycle, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_count, 2);
    chk("ovf_inst", inst_count, 8);
    ev_ready = 1; write_data = 16'h0200;
    step();
    chk("pp_head", ev_rdata, 16'h0101);
    chk("pp_drop", drop_count, 2);
    reg_write = 0;
    step();
    step();
    step();
    chk("pp_tail", ev_rdata, 16'h0200);
    chk("pp_tailcyc", ev_cycle, 10);
    step();
    chk("pp_empty", ev_valid, 0);
    do_reset();
    en = 1; ev_ready = 0;
    step();
    for (int i = 0; i < 7; i++) step();
    hlt = 1;
    step();
    chk("h_flags", ev_flags, 4'b1000);
    chk("h_cyc", ev_cycle, 7);
    chk("h_halted", halted, 1);
    chk("h_cycle", cycle_count, 8);
    hlt = 0; reg_write = 1;
    step();
    chk("h_frozen", cycle_count, 8);
    chk("h_inst", inst_count, 1);
    chk("h_hold", ev_valid, 1);
    ev_ready = 1;
    step();
    chk("h_drained", ev_valid, 0);
    do_reset();
    en = 1;
    step();
    for (int i = 0; i < 19; i++) step();
    chk("t_pre", timeout, 0);
    step();
    chk("t_timeout", timeout, 1);
    chk("t_cycle", cycle_count, 20);
    step();
    chk("t_frozen", cycle_count, 20);
    do_reset();
    en = 1;
    step();
    for (int i = 0; i < 19; i++) step();
    hlt = 1;
    step();
    chk("th_halted", halted, 1);
    chk("th_timeout", timeout, 0);
    chk("th_cycle", cycle_count, 20);
    do_reset();
    en = 1; ev_ready = 0;
    step();
    reg_write = 1;
    for (int i = 0; i < 3; i++) step();
    chk("mr_valid", ev_valid, 1);
    rst_n = 0;
    step();
    rst_n = 1;
    chk("mr_empty", ev_valid, 0);
    chk("mr_cycle", cycle_count, 0);
    chk("mr_inst", inst_count, 0);
    step();
    chk("mr_idle", ev_valid, 0);
    chk("mr_idlecyc", cycle_count, 0);
    step();
    chk("en_push", ev_valid, 1);
    chk("en_cycle", cycle_count, 1);
    en = 0;
    step();
    step();
    chk("en_hold_cyc", cycle_count, 1);
    chk("en_hold_inst", inst_count, 1);
    ev_ready = 1;
    step();
    chk("en_nopush", ev_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
